// File: rtl/findmajority_key_loader.sv
// findmajority_key_loader: serial key assembler that atomically arms a locked findMajority core
module findmajority_key_loader #(
  parameter int KEY_W = 511,
  parameter int CNT_W = 9
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             load_start,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  input  logic             host_ap_start,
  input  logic             core_ap_idle,
  output logic             core_ap_start,
  output logic [KEY_W-1:0] working_key,
  output logic             key_loaded,
  output logic [CNT_W-1:0] bit_count,
  output logic             load_err
);
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;
  state_t           state_q;
  logic [KEY_W-1:0] shift_q, shift_d, key_q;
  logic [CNT_W-1:0] cnt_q;
  logic             loaded_q, err_q, accept, last;
  // Handshake decode: a bit lands only while loading, and the final one commits
  always_comb begin
    accept  = key_valid && state_q == LOAD;
    last    = cnt_q == CNT_W'(KEY_W - 1);
    shift_d = {shift_q[KEY_W-2:0], key_bit};
  end
  // Load FSM; a restart request always beats a bit presented in the same cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ARMED: begin
          if (load_start) begin
            if (core_ap_idle) begin
              state_q  <= LOAD;
              shift_q  <= '0;
              cnt_q    <= '0;
              loaded_q <= 1'b0;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (load_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (accept) begin
            shift_q <= shift_d;
            if (last) begin
              key_q    <= shift_d;
              loaded_q <= 1'b1;
              state_q  <= ARMED;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Core start is gated by the committed key with no added latency
  always_comb begin
    key_ready     = state_q == LOAD;
    core_ap_start = host_ap_start & loaded_q;
    working_key   = key_q;
    key_loaded    = loaded_q;
    bit_count     = cnt_q;
    load_err      = err_q;
  end
endmodule

// File: tb/tb_findmajority_key_loader.sv
// tb_findmajority_key_loader: scoreboard bench for an 8-bit and a full-width key loader
module tb_findmajority_key_loader;
  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic s_rst_n, s_load, s_valid, s_bit, s_host, s_idle;
  logic s_ready, s_start, s_loaded, s_err;
  logic [7:0] s_key;
  logic [3:0] s_cnt;

  logic b_rst_n, b_load, b_valid, b_bit, b_host, b_idle;
  logic b_ready, b_start, b_loaded, b_err;
  logic [510:0] b_key;
  logic [8:0] b_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [510:0] big_q[$];
  logic [510:0] golden;

  findmajority_key_loader #(.KEY_W(8), .CNT_W(4)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(s_rst_n), .load_start(s_load), .key_valid(s_valid),
    .key_bit(s_bit), .key_ready(s_ready), .host_ap_start(s_host), .core_ap_idle(s_idle),
    .core_ap_start(s_start), .working_key(s_key), .key_loaded(s_loaded),
    .bit_count(s_cnt), .load_err(s_err));

  findmajority_key_loader dut511 (
    .ap_clk(ap_clk), .ap_rst_n(b_rst_n), .load_start(b_load), .key_valid(b_valid),
    .key_bit(b_bit), .key_ready(b_ready), .host_ap_start(b_host), .core_ap_idle(b_idle),
    .core_ap_start(b_start), .working_key(b_key), .key_loaded(b_loaded),
    .bit_count(b_cnt), .load_err(b_err));

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_load;
    s_load = 1'b1;
    tick;
    s_load = 1'b0;
  endtask

  task automatic stream8(input logic [7:0] k, input bit gaps, input logic [7:0] prev);
    logic [7:0] e;
    int n;
    n = 0;
    exp_q.push_back(k);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_bit = ~k[i];
        tick;
        vectors++;
        if (s_cnt !== 4'(n) || s_key !== prev) begin
          miscompares++;
          $display("FAIL gap_hold cnt=%0d key=%h want cnt=%0d key=%h", s_cnt, s_key, n, prev);
        end
      end
      vectors++;
      if (s_ready !== 1'b1 || s_loaded !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_load ready=%b loaded=%b want 1 0", s_ready, s_loaded);
      end
      s_valid = 1'b1;
      s_bit = k[i];
      tick;
      n++;
      if (i > 0) begin
        vectors++;
        if (s_cnt !== 4'(n) || s_key !== prev || s_loaded !== 1'b0) begin
          miscompares++;
          $display("FAIL mid_load cnt=%0d key=%h loaded=%b want %0d %h 0", s_cnt, s_key, s_loaded, n, prev);
        end
      end
    end
    s_valid = 1'b0;
    vectors++;
    if (s_loaded === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (s_key !== e || s_ready !== 1'b0 || s_cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL commit key=%h ready=%b cnt=%0d want %h 0 0", s_key, s_ready, s_cnt, e);
      end
    end else begin
      miscompares++;
      $display("FAIL commit_missing loaded=%b want 1", s_loaded);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    s_rst_n = 1'b0; s_load = 0; s_valid = 0; s_bit = 0; s_host = 0; s_idle = 1;
    b_rst_n = 1'b0; b_load = 0; b_valid = 0; b_bit = 0; b_host = 0; b_idle = 1;
    tick;
    tick;
    vectors++;
    if ({s_key, s_cnt, s_loaded, s_ready, s_err, s_start} !== '0) begin
      miscompares++;
      $display("FAIL reset_state key=%h cnt=%0d loaded=%b ready=%b err=%b start=%b want 0",
               s_key, s_cnt, s_loaded, s_ready, s_err, s_start);
    end
    s_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_host_gate;
    s_host = 1'b1;
    tick;
    vectors++;
    if (s_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_gated got %b want 0", s_start);
    end
  endtask

  task automatic test_idle_refuse;
    s_idle = 1'b0;
    pulse_load;
    vectors++;
    if (s_err !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_refuse err=%b ready=%b want 1 0", s_err, s_ready);
    end
    s_idle = 1'b1;
  endtask

  task automatic test_basic;
    pulse_load;
    vectors++;
    if (s_err !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_enter err=%b ready=%b want 0 1", s_err, s_ready);
    end
    stream8(8'hB2, 1'b0, 8'h00);
    vectors++;
    if (s_start !== 1'b1) begin
      miscompares++;
      $display("FAIL start_on_commit got %b want 1", s_start);
    end
  endtask

  task automatic test_not_consumed;
    s_valid = 1'b1;
    s_bit = 1'b1;
    repeat (3) tick;
    s_valid = 1'b0;
    vectors++;
    if (s_cnt !== 4'd0 || s_key !== 8'hB2 || s_ready !== 1'b0 || s_loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL armed_ignore cnt=%0d key=%h ready=%b loaded=%b want 0 b2 0 1",
               s_cnt, s_key, s_ready, s_loaded);
    end
  endtask

  task automatic test_busy_refuse;
    s_idle = 1'b0;
    pulse_load;
    vectors++;
    if (s_err !== 1'b1 || s_key !== 8'hB2 || s_loaded !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_refuse err=%b key=%h loaded=%b ready=%b want 1 b2 1 0",
               s_err, s_key, s_loaded, s_ready);
    end
    for (int i = 0; i < 4; i++) begin
      s_host = i[0];
      #1;
      vectors++;
      if (s_start !== logic'(i[0])) begin
        miscompares++;
        $display("FAIL start_follow got %b want %b", s_start, i[0]);
      end
      tick;
    end
    s_host = 1'b1;
    s_idle = 1'b1;
  endtask

  task automatic test_gaps;
    s_rst_n = 1'b0;
    tick;
    s_rst_n = 1'b1;
    tick;
    pulse_load;
    stream8(8'hB2, 1'b1, 8'h00);
  endtask

  task automatic test_restart;
    logic [7:0] junk;
    junk = 8'hFF;
    pulse_load;
    vectors++;
    if (s_err !== 1'b0 || s_loaded !== 1'b0 || s_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_enter err=%b loaded=%b start=%b want 0 0 0", s_err, s_loaded, s_start);
    end
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_bit = junk[i];
      tick;
    end
    s_load = 1'b1;
    tick;
    s_load = 1'b0;
    s_valid = 1'b0;
    vectors++;
    if (s_cnt !== 4'd0 || s_ready !== 1'b1 || s_key !== 8'hB2) begin
      miscompares++;
      $display("FAIL restart cnt=%0d ready=%b key=%h want 0 1 b2", s_cnt, s_ready, s_key);
    end
    stream8(8'h5A, 1'b0, 8'hB2);
  endtask

  task automatic test_restart_on_commit;
    logic [7:0] k;
    k = 8'h96;
    pulse_load;
    for (int i = 7; i >= 1; i--) begin
      s_valid = 1'b1;
      s_bit = k[i];
      tick;
    end
    s_bit = k[0];
    s_load = 1'b1;
    tick;
    s_load = 1'b0;
    s_valid = 1'b0;
    vectors++;
    if (s_loaded !== 1'b0 || s_ready !== 1'b1 || s_cnt !== 4'd0 || s_key !== 8'h5A) begin
      miscompares++;
      $display("FAIL restart_wins loaded=%b ready=%b cnt=%0d key=%h want 0 1 0 5a",
               s_loaded, s_ready, s_cnt, s_key);
    end
    stream8(8'hC3, 1'b0, 8'h5A);
  endtask

  task automatic test_big;
    logic [510:0] e;
    for (int j = 0; j < 511; j++) golden[j] = ((j * 37 + 11) % 7) < 3;
    b_load = 1'b1;
    tick;
    b_load = 1'b0;
    big_q.push_back(golden);
    for (int i = 510; i >= 0; i--) begin
      b_valid = 1'b1;
      b_bit = golden[i];
      tick;
      if (i == 311) begin
        vectors++;
        if (b_cnt !== 9'd200 || b_loaded !== 1'b0 || b_key !== '0) begin
          miscompares++;
          $display("FAIL big_mid cnt=%0d loaded=%b want 200 0", b_cnt, b_loaded);
        end
      end
    end
    b_valid = 1'b0;
    vectors++;
    if (b_loaded === 1'b1 && big_q.size() > 0) begin
      e = big_q.pop_front();
      if (b_key !== e || b_ready !== 1'b0 || b_cnt !== 9'd0) begin
        miscompares++;
        $display("FAIL big_commit key_hi=%h ready=%b cnt=%0d want %h 0 0", b_key[510:447], b_ready, b_cnt, e[510:447]);
      end
    end else begin
      miscompares++;
      $display("FAIL big_commit_missing loaded=%b want 1", b_loaded);
    end
    b_load = 1'b1;
    tick;
    b_load = 1'b0;
    for (int i = 0; i < 200; i++) begin
      b_valid = 1'b1;
      b_bit = ~golden[i];
      tick;
    end
    b_valid = 1'b0;
    b_host = 1'b1;
    vectors++;
    if (b_cnt !== 9'd200 || b_key !== golden) begin
      miscompares++;
      $display("FAIL big_reload cnt=%0d want 200", b_cnt);
    end
    #2;
    b_rst_n = 1'b0;
    #1;
    vectors++;
    if ({b_key, b_cnt, b_loaded, b_ready, b_err, b_start} !== '0) begin
      miscompares++;
      $display("FAIL async_reset cnt=%0d loaded=%b ready=%b err=%b start=%b key_nonzero=%b want 0",
               b_cnt, b_loaded, b_ready, b_err, b_start, |b_key);
    end
    tick;
    #2;
    b_rst_n = 1'b1;
    tick;
    b_valid = 1'b1;
    tick;
    b_valid = 1'b0;
    vectors++;
    if (b_ready !== 1'b0 || b_cnt !== 9'd0 || b_loaded !== 1'b0 || b_key !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle ready=%b cnt=%0d loaded=%b want 0 0 0", b_ready, b_cnt, b_loaded);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_host_gate;
    test_idle_refuse;
    test_basic;
    test_not_consumed;
    test_busy_refuse;
    test_gaps;
    test_restart;
    test_restart_on_commit;
    test_big;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/findmajority_key_loader.md
Name: findmajority_key_loader

Overview:
- Upstream stage of the logic-locked findMajority core.
- Receives the unlock key as a serial bit stream with a valid/ready handshake and assembles it into a KEY_W-bit register.
- Commits the whole key atomically to the core's working_key input.
- Gates the host's ap_start so the core cannot start until a complete key is committed. No key reload is accepted while the core is busy.

Parameters:
KEY_W, 511, width of working_key and number of serial bits per load
CNT_W, 9, bit-counter width; must satisfy 2^CNT_W >= KEY_W

Ports:
ap_clk  input  1  clock; all state updates on rising edge
ap_rst_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle request to begin or restart a key load
key_valid  input  1  serial key bit present on key_bit
key_bit  input  1  serial key data, MSB first
key_ready  output  1  loader accepting bits; high only in LOAD
host_ap_start  input  1  ap_start from the host/controller
core_ap_idle  input  1  ap_idle from the locked core
core_ap_start  output  1  gated ap_start to the locked core
working_key  output  KEY_W  committed key to the locked core
key_loaded  output  1  working_key is a complete, committed key
bit_count  output  CNT_W  bits accepted in the current load
load_err  output  1  sticky: load_start refused because core busy

Behaviour:
- Reset (ap_rst_n low, asynchronous, any state):
  - state=IDLE.
  - Shift register, working_key and bit_count = 0.
  - key_loaded, key_ready, load_err = 0.
  - core_ap_start is 0, since key_loaded=0.
- States: IDLE, LOAD, ARMED. Encoding is free.
- Handshake: a bit is accepted in a cycle where key_valid=1 and key_ready=1. On acceptance:
  - shift <= {shift[KEY_W-2:0], key_bit};
  - bit_count <= bit_count+1.
  - key_bit is ignored when key_valid=0.
- Bit order: the first accepted bit ends in working_key[KEY_W-1], the last in working_key[0].
- IDLE:
  - key_ready=0.
  - load_start=1 with core_ap_idle=1: go to LOAD, bit_count<=0, shift<=0, load_err<=0.
  - load_start=1 with core_ap_idle=0: stay, load_err<=1.
- LOAD:
  - key_ready=1 combinationally from state.
  - key_loaded=0 throughout. working_key holds its previous value and does not change until commit.
  - The acceptance that brings bit_count to KEY_W (bit_count==KEY_W-1 at acceptance) commits on the same edge:
    - working_key <= {shift[KEY_W-2:0], key_bit};
    - key_loaded<=1;
    - state<=ARMED; bit_count<=0.
    - key_ready is therefore low in the following cycle.
  - load_start=1 in LOAD restarts: bit_count<=0, shift<=0. A bit presented in the same cycle is discarded, so restart wins.
- ARMED:
  - key_ready=0; key_loaded=1.
  - load_start=1 with core_ap_idle=1: go to LOAD, key_loaded<=0, bit_count<=0, shift<=0, load_err<=0.
  - load_start=1 with core_ap_idle=0: refused, load_err<=1, stays ARMED with key intact.
- core_ap_start = host_ap_start & key_loaded, combinational with no added latency. The host's ap_ctrl_hs protocol passes through unchanged once armed.
- Simultaneous events:
  - load_start in the same cycle as the committing bit: restart wins, no commit, state stays LOAD.
  - Reset during LOAD discards the partial key and clears working_key.
- Bits offered while key_ready=0 are not consumed. The bit counter never exceeds KEY_W-1.

Test Plan:
- KEY_W=8: reset, load_start, stream 1,0,1,1,0,0,1,0 with key_valid always 1 -> key_ready high 8 cycles; working_key=8'hB2 and key_loaded=1 on the edge of the 8th bit; key_ready=0 next cycle.
- KEY_W=8, same stream with key_valid deasserted every other cycle -> identical result 8'hB2; bit_count increments only on valid cycles; working_key unchanged (0) until commit.
- Armed with 8'hB2, core_ap_idle=0, pulse load_start -> load_err=1, state ARMED, working_key=8'hB2, core_ap_start follows host_ap_start.
- Mid-load after 5 bits, pulse load_start then stream 8'h5A -> working_key=8'h5A, not a mix with the earlier bits; key_loaded=0 until the 8th new bit.
- host_ap_start=1 before any load -> core_ap_start=0. After load completes -> core_ap_start=1 in the same cycle key_loaded rises.
- Default KEY_W=511, load the 511-bit golden key pattern, then assert ap_rst_n low mid-reload at bit 200 -> all outputs are 0 immediately (asynchronous); after release, state is IDLE.
